// File: rtl/trace_record_emitter_v12.sv
// Trace record emitter: captures stage timestamps, computes clamped per-stage deltas,
// packs a 64-byte v1.2 record and queues it in a FIFO for a ready/valid consumer.
module trace_record_emitter_v12 #(
  parameter int FIFO_DEPTH  = 16,
  parameter int CORE_ID     = 1,
  parameter int EMIT_ENABLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cap_valid,
  input  logic [63:0]  cap_data,
  input  logic [63:0]  t_ingress,
  input  logic [63:0]  t_core_in,
  input  logic [63:0]  t_core_out,
  input  logic [63:0]  t_risk_in,
  input  logic [63:0]  t_risk_out,
  input  logic [63:0]  t_egress_in,
  input  logic [63:0]  t_egress,
  output logic         trace_valid,
  input  logic         trace_ready,
  output logic [511:0] trace_data,
  output logic [6:0]   trace_size,
  output logic [31:0]  seq_no,
  output logic [31:0]  trace_drop_count,
  output logic [31:0]  anomaly_count
);

  localparam int           AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]  DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0]  CORE_ID_C = 16'(CORE_ID);
  localparam bit           EMIT_ON   = (EMIT_ENABLE != 0);

  // Returns {flag_neg, flag_sat, delta}: negative results clamp to 0, wide ones to all-ones.
  function automatic logic [33:0] clamp_delta(input logic [63:0] minu, input logic [63:0] subt);
    logic [63:0] diff;
    diff = minu - subt;
    if (subt > minu)
      clamp_delta = {2'b10, 32'd0};
    else if (diff[63:32] != 32'd0)
      clamp_delta = {2'b01, 32'hFFFF_FFFF};
    else
      clamp_delta = {2'b00, diff[31:0]};
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [33:0]  d_ing_c, d_core_c, d_risk_c, d_eg_c;
  logic [511:0] record_c;

  always_comb begin
    d_ing_c  = clamp_delta(t_core_in,  t_ingress);
    d_core_c = clamp_delta(t_core_out, t_core_in);
    d_risk_c = clamp_delta(t_risk_out, t_risk_in);
    d_eg_c   = clamp_delta(t_egress,   t_egress_in);
    record_c            = '0;
    record_c[7:0]       = 8'h02;
    record_c[15:8]      = 8'h01;
    record_c[31:16]     = CORE_ID_C;
    record_c[63:32]     = seq_no;
    record_c[127:64]    = t_ingress;
    record_c[191:128]   = t_egress;
    record_c[255:192]   = cap_data;
    record_c[287:256]   = d_ing_c[31:0];
    record_c[319:288]   = d_core_c[31:0];
    record_c[351:320]   = d_risk_c[31:0];
    record_c[383:352]   = d_eg_c[31:0];
    record_c[384]       = d_ing_c[33] | d_core_c[33] | d_risk_c[33] | d_eg_c[33];
    record_c[385]       = d_ing_c[32] | d_core_c[32] | d_risk_c[32] | d_eg_c[32];
  end

  // ---- stage p0: capture and delta compute ----
  logic         vld_p0;
  logic [511:0] record_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      seq_no <= 32'd0;
    end else begin
      vld_p0 <= cap_valid;
      if (cap_valid) seq_no <= seq_no + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (cap_valid) record_p0 <= record_c;
  end

  // ---- stage p1: FIFO write, drop and anomaly accounting ----
  logic [511:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, wr_en, drop_p1, anom_p1;

  always_comb begin
    full    = (count == DEPTH_C);
    pop     = trace_valid && trace_ready;
    wr_en   = vld_p0 && EMIT_ON && (!full || pop);
    drop_p1 = vld_p0 && !wr_en;
    anom_p1 = vld_p0 && (record_p0[384] || record_p0[385]);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= record_p0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      trace_drop_count <= 32'd0;
      anomaly_count    <= 32'd0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop_p1) trace_drop_count <= sat_inc(trace_drop_count);
      if (anom_p1) anomaly_count    <= sat_inc(anomaly_count);
    end
  end

  assign trace_valid = (count != '0);
  assign trace_data  = mem[rd_ptr];
  assign trace_size  = 7'd64;

endmodule
